// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - read-side controller streaming RAM words out through a 2-entry buffer
//
// Purpose: on start, reads `length` consecutive words beginning at `base`
// (wrapping at DEPTH) from a 1-cycle-latency RAM and emits them in address
// order on a valid/ready stream. A 2-entry FIFO buffer absorbs the RAM read
// latency and downstream stalls; reads are only issued when a slot is
// guaranteed, so no word is ever dropped or duplicated.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, base, length request pulse and its parameters, sampled only in IDLE
//   busy, done          busy in READ/DRAIN/DONE; done is a 1-cycle pulse
//   ram_raddr, ram_ren  RAM read address / enable
//   ram_dout            RAM read data, valid the cycle after ram_ren
//   m_valid, m_data     stream output (head of buffer)
//   m_ready             downstream accept

module ram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_ren,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;

  // 2-entry FIFO: storage, pointers and occupancy
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;

  logic                  push;
  logic                  pop;
  logic [2:0]            credit_used;
  logic                  credit_ok;
  logic                  issue;

  // The RAM answers exactly one cycle after ram_ren, so the in-flight flag
  // doubles as the buffer push strobe.
  assign push      = inflight_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[rd_ptr_q];
  assign pop       = m_valid & m_ready;

  // A read may issue only if its data is guaranteed a slot when it returns:
  // occupancy + in-flight - (word leaving this cycle) must stay below 2.
  assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit_ok   = credit_used < (3'd2 + {2'b00, pop});

  assign issue     = (state_q == S_READ) && (issue_cnt_q != '0) && credit_ok;
  assign ram_ren   = issue;
  assign ram_raddr = addr_q;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = issue;
    rd_ptr_d    = rd_ptr_q ^ pop;
    wr_ptr_d    = wr_ptr_q ^ push;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};

    if (pop && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = S_READ;
            addr_d      = base;
            issue_cnt_d = length;
            out_cnt_d   = length;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          // Explicit wrap so DEPTH need not be a power of two.
          addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          if (issue_cnt_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      if (push) begin
        buf_q[wr_ptr_q] <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - self-checking bench for ram_stream_reader

module tb_ram_stream_reader;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_raddr;
  logic          ram_ren;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  logic [DW-1:0] mem [DEPTH];

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_raddr (ram_raddr),
    .ram_ren   (ram_ren),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  // 1-cycle latency RAM model
  always @(posedge clk) begin
    if (ram_ren) ram_dout <= mem[ram_raddr];
  end

  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];

  int errors = 0;
  int checks = 0;
  int ren_cnt, pop_cnt, done_cnt, valid_cnt;
  int cyc_no = 0;
  int start_cyc, first_valid_cyc, done_cyc;
  int occ_m = 0;
  int infl_m = 0;
  bit held = 0;
  logic [DW-1:0] held_data;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample outputs at the falling edge, update the reference model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic cyc();
    logic pop;
    @(negedge clk);
    pop = m_valid && m_ready;
    if (rst_n) begin
      chk("valid_vs_model", {31'b0, m_valid}, {31'b0, (occ_m != 0)});
      if (held && m_valid) chk("stall_hold", m_data, held_data);
      if (ram_ren) begin
        ren_cnt++;
        chk("credit", {31'b0, ((occ_m + infl_m - int'(pop)) < 2)}, 32'd1);
        if (exp_addr.size() == 0) chk("unexpected_ren", {31'b0, ram_ren}, 32'd0);
        else chk("raddr", {28'b0, ram_raddr}, {28'b0, exp_addr.pop_front()});
      end
      if (pop) begin
        pop_cnt++;
        if (exp_data.size() == 0) chk("unexpected_word", {31'b0, m_valid}, 32'd0);
        else chk("data", m_data, exp_data.pop_front());
      end
      if (m_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc_no;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_no;
      end
      held      = m_valid && !m_ready;
      held_data = m_data;
      occ_m     = occ_m + infl_m - int'(pop);
      infl_m    = int'(ram_ren);
    end else begin
      occ_m  = 0;
      infl_m = 0;
      held   = 0;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int b, input int len);
    ren_cnt = 0; pop_cnt = 0; done_cnt = 0; valid_cnt = 0;
    first_valid_cyc = -1;
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(mem[(b + i) % DEPTH]);
      exp_addr.push_back(AW'((b + i) % DEPTH));
    end
    base      = AW'(b);
    length    = (AW + 1)'(len);
    start     = 1'b1;
    start_cyc = cyc_no;
    cyc();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int cnt);
    int d0;
    d0  = done_cnt;
    cnt = 0;
    while (done_cnt == d0 && cnt < max) begin
      cyc();
      cnt++;
    end
    chk("done_within_budget", {31'b0, (cnt < max)}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    {31'b0, busy},    32'd0);
    chk({tag, "_done"},    {31'b0, done},    32'd0);
    chk({tag, "_ren"},     {31'b0, ram_ren}, 32'd0);
    chk({tag, "_raddr"},   {28'b0, ram_raddr}, 32'd0);
    chk({tag, "_mvalid"},  {31'b0, m_valid}, 32'd0);
    chk({tag, "_mdata"},   m_data,           32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    rst_n = 1'b0; start = 1'b0; base = '0; length = '0; m_ready = 1'b1;
    cyc(); cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // base=3 length=4, ready high: 103..106 back to back
    start_xfer(3, 4);
    run_until_done(40, n);
    chk("t1_ren_count", ren_cnt, 4);
    chk("t1_pop_count", pop_cnt, 4);
    chk("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
    chk("t1_done_lat", done_cyc - start_cyc, 7);
    chk("t1_queue_empty", exp_data.size(), 0);
    cyc(); cyc();
    chk("t1_single_done", done_cnt, 1);
    chk("t1_idle_busy", {31'b0, busy}, 32'd0);

    // wrap: base=14 length=5
    start_xfer(14, 5);
    run_until_done(40, n);
    chk("t2_ren_count", ren_cnt, 5);
    chk("t2_pop_count", pop_cnt, 5);
    chk("t2_addr_queue_empty", exp_addr.size(), 0);
    cyc();

    // length=0: no RAM access, done the cycle after start
    start_xfer(5, 0);
    chk("t3_done_now", {31'b0, done}, 32'd1);
    chk("t3_busy_now", {31'b0, busy}, 32'd1);
    cyc(); cyc(); cyc();
    chk("t3_done_count", done_cnt, 1);
    chk("t3_done_lat", done_cyc - start_cyc, 1);
    chk("t3_ren_count", ren_cnt, 0);
    chk("t3_valid_count", valid_cnt, 0);
    chk("t3_busy_after", {31'b0, busy}, 32'd0);

    // m_ready pattern 1,0,0 repeating, length=8 with wrap
    start_xfer(12, 8);
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      m_ready = (n % 3 == 0);
      cyc();
      n++;
    end
    chk("t4_done_within_budget", {31'b0, (n < 200)}, 32'd1);
    m_ready = 1'b1;
    chk("t4_ren_count", ren_cnt, 8);
    chk("t4_pop_count", pop_cnt, 8);
    chk("t4_queue_empty", exp_data.size(), 0);
    cyc();

    // reset mid-transfer after the 2nd word
    start_xfer(0, 8);
    n = 0;
    while (pop_cnt < 2 && n < 40) begin
      cyc();
      n++;
    end
    chk("t5_two_words", pop_cnt, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_data.delete();
    exp_addr.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("t5_no_done_after_abort", done_cnt, 0);
    chk("t5_no_valid_after_abort", {31'b0, m_valid}, 32'd0);
    start_xfer(0, 2);
    run_until_done(40, n);
    chk("t5_pop_count", pop_cnt, 2);
    chk("t5_queue_empty", exp_data.size(), 0);
    cyc();

    // start while busy is ignored
    start_xfer(0, 3);
    cyc();
    base = AW'(9); length = 5'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(40, n);
    cyc(); cyc(); cyc(); cyc();
    chk("t6_ren_count", ren_cnt, 3);
    chk("t6_pop_count", pop_cnt, 3);
    chk("t6_done_count", done_cnt, 1);
    chk("t6_busy_after", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
